float_divider: RTL and testbench

//  Multi-cycle IEEE-754 single-precision mantissa/exponent divider (a / b) for the FPU datapath.

---
 rtl/float_divider.sv | 172 +++++++++++++++++
 tb/tb_float_divider.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_divider.sv
// Multi-cycle restoring divider for IEEE-754 single mantissas/exponents: unrounded quotient, round/sticky bits and IV/DZ flags.
// Latency: 25/ITER_PER_CYCLE clocks from load to the ready pulse; special cases answer on the load edge itself.
// No backpressure: a new load is always accepted and aborts any divide in flight; ready is a single-cycle pulse.
module float_divider #(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        op_div,
  input  logic [23:0] man_a,
  input  logic [23:0] man_b,
  input  logic [9:0]  exp_a,
  input  logic [9:0]  exp_b,
  input  logic        sgn_a,
  input  logic        sgn_b,
  input  logic        zero_a,
  input  logic        zero_b,
  input  logic        inf_a,
  input  logic        inf_b,
  input  logic        sNaN_a,
  input  logic        sNaN_b,
  input  logic        qNaN_a,
  input  logic        qNaN_b,
  output logic [23:0] man_y,
  output logic [9:0]  exp_y,
  output logic        sgn_y,
  output logic        round_bit,
  output logic        sticky_bit,
  output logic        IV,
  output logic        DZ,
  output logic        final_res,
  output logic        ready
);

  localparam int         LAT      = 25 / ITER_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(LAT - 1);

  typedef enum logic {IDLE, CALC} state_t;
  state_t state_q, state_d;

  logic [25:0] rem_q;
  logic [23:0] div_q;
  logic [24:0] q_q;
  logic [4:0]  cnt_q;

  logic        iv_c, nan_c, inf_res_c, zero_res_c, special_c, man_lt_c, last_c;
  logic [23:0] spc_man_c;
  logic [9:0]  spc_exp_c;
  logic        spc_sgn_c, spc_dz_c;
  logic [9:0]  exp_norm_c;
  logic [25:0] rem_init_c;
  logic [25:0] rem_c;
  logic [24:0] q_c;

  assign iv_c       = sNaN_a | sNaN_b | (zero_a & zero_b) | (inf_a & inf_b);
  assign nan_c      = iv_c | qNaN_a | qNaN_b;
  assign inf_res_c  = inf_a | zero_b;
  assign zero_res_c = zero_a | inf_b;
  assign special_c  = nan_c | inf_res_c | zero_res_c;
  assign man_lt_c   = (man_a < man_b);
  assign last_c     = (state_q == CALC) && (cnt_q == LAST_CNT);

  // Pre-normalise so the first quotient bit is always 1: a smaller dividend is doubled and the exponent drops by one.
  assign exp_norm_c = exp_a - exp_b - {9'd0, man_lt_c};
  assign rem_init_c = man_lt_c ? {1'b0, man_a, 1'b0} : {2'b00, man_a};

  // Special-case result selection, highest priority first: NaN, then infinity, then zero.
  always_comb begin
    spc_man_c = 24'h000000;
    spc_exp_c = 10'h000;
    spc_sgn_c = sgn_a ^ sgn_b;
    spc_dz_c  = 1'b0;
    if (nan_c) begin
      spc_man_c = 24'hC00000;
      spc_exp_c = 10'h0FF;
      spc_sgn_c = 1'b0;
    end else if (inf_res_c) begin
      spc_man_c = 24'h800000;
      spc_exp_c = 10'h0FF;
      spc_dz_c  = zero_b & ~inf_a;
    end
  end

  // Chain ITER_PER_CYCLE restoring steps; quotient bits shift in at the LSB so the first bit lands in q[24].
  always_comb begin
    rem_c = rem_q;
    q_c   = q_q;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      if (rem_c >= {2'b00, div_q}) begin
        rem_c = rem_c - {2'b00, div_q};
        q_c   = {q_c[23:0], 1'b1};
      end else begin
        q_c   = {q_c[23:0], 1'b0};
      end
      rem_c = {rem_c[24:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: loads win over everything; a divide returns to IDLE on its last iteration edge.
  always_comb begin
    state_d = state_q;
    if (load)        state_d = (op_div && !special_c) ? CALC : IDLE;
    else if (last_c) state_d = IDLE;
  end

  // Datapath and output registers: load handling, iteration, and result capture on the final edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q      <= '0;
      div_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      man_y      <= '0;
      exp_y      <= '0;
      sgn_y      <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
      IV         <= 1'b0;
      DZ         <= 1'b0;
      final_res  <= 1'b0;
      ready      <= 1'b0;
    end else if (load) begin
      rem_q      <= '0;
      div_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      man_y      <= '0;
      exp_y      <= '0;
      sgn_y      <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
      IV         <= 1'b0;
      DZ         <= 1'b0;
      final_res  <= 1'b0;
      ready      <= 1'b0;
      if (op_div && special_c) begin
        man_y     <= spc_man_c;
        exp_y     <= spc_exp_c;
        sgn_y     <= spc_sgn_c;
        IV        <= iv_c;
        DZ        <= spc_dz_c;
        final_res <= 1'b1;
        ready     <= 1'b1;
      end else if (op_div) begin
        rem_q <= rem_init_c;
        div_q <= man_b;
        exp_y <= exp_norm_c;
        sgn_y <= sgn_a ^ sgn_b;
      end
    end else if (state_q == CALC) begin
      rem_q <= rem_c;
      q_q   <= q_c;
      cnt_q <= cnt_q + 5'd1;
      ready <= last_c;
      if (last_c) begin
        man_y      <= q_c[24:1];
        round_bit  <= q_c[0];
        sticky_bit <= |rem_c;
      end
    end else begin
      ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_float_divider.sv
// Bench for float_divider: three instances (1, 5, 25 bits per clock) share one stimulus stream.
// Directed special cases, abort and reset scenarios, then a random sweep against an arithmetic quotient model.
module tb_float_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load, op_div;
  logic [23:0] man_a, man_b;
  logic [9:0]  exp_a, exp_b;
  logic        sgn_a, sgn_b, zero_a, zero_b, inf_a, inf_b, sNaN_a, sNaN_b, qNaN_a, qNaN_b;

  logic [23:0] man_y_o [3];
  logic [9:0]  exp_y_o [3];
  logic        sgn_y_o [3];
  logic        round_o [3];
  logic        sticky_o[3];
  logic        iv_o    [3];
  logic        dz_o    [3];
  logic        fr_o    [3];
  logic        ready_o [3];

  int itr[3] = '{1, 5, 25};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    float_divider #(.ITER_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 5 : 25))) u_dut (
      .clk(clk), .reset(reset), .load(load), .op_div(op_div),
      .man_a(man_a), .man_b(man_b), .exp_a(exp_a), .exp_b(exp_b),
      .sgn_a(sgn_a), .sgn_b(sgn_b), .zero_a(zero_a), .zero_b(zero_b),
      .inf_a(inf_a), .inf_b(inf_b), .sNaN_a(sNaN_a), .sNaN_b(sNaN_b),
      .qNaN_a(qNaN_a), .qNaN_b(qNaN_b),
      .man_y(man_y_o[g]), .exp_y(exp_y_o[g]), .sgn_y(sgn_y_o[g]),
      .round_bit(round_o[g]), .sticky_bit(sticky_o[g]), .IV(iv_o[g]), .DZ(dz_o[g]),
      .final_res(fr_o[g]), .ready(ready_o[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured at the first ready pulse seen by collect().
  int          lat   [3];
  int          pulses[3];
  logic [23:0] c_man [3];
  logic [9:0]  c_exp [3];
  logic        c_sgn [3], c_rnd[3], c_stk[3], c_iv[3], c_dz[3], c_fr[3];

  // All outputs of instance g packed: man, exp, sgn, round, sticky, IV, DZ, final_res, ready.
  function automatic logic [40:0] outs(input int g);
    return {man_y_o[g], exp_y_o[g], sgn_y_o[g], round_o[g], sticky_o[g],
            iv_o[g], dz_o[g], fr_o[g], ready_o[g]};
  endfunction

  task automatic set_ops(input logic [23:0] ma, input logic [23:0] mb,
                         input logic [9:0] ea, input logic [9:0] eb,
                         input logic sa, input logic sb);
    man_a = ma; man_b = mb; exp_a = ea; exp_b = eb; sgn_a = sa; sgn_b = sb;
    zero_a = 0; zero_b = 0; inf_a = 0; inf_b = 0;
    sNaN_a = 0; sNaN_b = 0; qNaN_a = 0; qNaN_b = 0;
  endtask

  // One-clock load strobe; returns 1 time unit after the load edge.
  task automatic pulse_load(input logic div);
    @(negedge clk);
    op_div = div;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load   = 1'b0;
  endtask

  // Watch all instances for up to 'limit' clocks, recording first-pulse latency and outputs.
  task automatic collect(input int limit);
    for (int g = 0; g < 3; g++) begin
      lat[g] = -1;
      pulses[g] = 0;
    end
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (ready_o[g] === 1'b1) begin
          pulses[g]++;
          if (lat[g] < 0) begin
            lat[g] = c;
            c_man[g] = man_y_o[g]; c_exp[g] = exp_y_o[g]; c_sgn[g] = sgn_y_o[g];
            c_rnd[g] = round_o[g]; c_stk[g] = sticky_o[g];
            c_iv[g] = iv_o[g]; c_dz[g] = dz_o[g]; c_fr[g] = fr_o[g];
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; op_div = 1'b0;
    set_ops(24'h0, 24'h0, 10'h0, 10'h0, 1'b0, 1'b0);
    #12;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (outs(g) !== '0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got %h expected 0", g, outs(g));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (outs(g) !== '0) begin
        n_fail++;
        $display("FAIL idle_after_reset inst%0d: got %h expected 0", g, outs(g));
      end
    end
  endtask

  task automatic test_directed_divides;
    // 1.5 / 1.0
    set_ops(24'hC00000, 24'h800000, 10'h0, 10'h0, 1'b0, 1'b0);
    pulse_load(1'b1);
    collect(30);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (lat[g] !== 25 / itr[g]) begin
        n_fail++;
        $display("FAIL lat_1p5_div_1 inst%0d: got %0d expected %0d", g, lat[g], 25 / itr[g]);
      end
      n_checks++;
      if ({c_man[g], c_exp[g], c_sgn[g], c_rnd[g], c_stk[g], c_fr[g], c_iv[g], c_dz[g]} !==
          {24'hC00000, 10'h000, 6'b000000}) begin
        n_fail++;
        $display("FAIL res_1p5_div_1 inst%0d: got man %h exp %h s%b r%b st%b fr%b iv%b dz%b expected man c00000 exp 000 rest 0",
                 g, c_man[g], c_exp[g], c_sgn[g], c_rnd[g], c_stk[g], c_fr[g], c_iv[g], c_dz[g]);
      end
    end
    // 1.0 / 1.5
    set_ops(24'h800000, 24'hC00000, 10'h0, 10'h0, 1'b0, 1'b0);
    pulse_load(1'b1);
    collect(30);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (lat[g] !== 25 / itr[g]) begin
        n_fail++;
        $display("FAIL lat_1_div_1p5 inst%0d: got %0d expected %0d", g, lat[g], 25 / itr[g]);
      end
      n_checks++;
      if ({c_man[g], c_exp[g], c_sgn[g], c_rnd[g], c_stk[g], c_fr[g]} !==
          {24'hAAAAAA, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL res_1_div_1p5 inst%0d: got man %h exp %h s%b r%b st%b fr%b expected man aaaaaa exp 3ff s0 r1 st1 fr0",
                 g, c_man[g], c_exp[g], c_sgn[g], c_rnd[g], c_stk[g], c_fr[g]);
      end
    end
  endtask

  task automatic test_invalid;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin set_ops(24'h0, 24'h0, 10'h0, 10'h0, 1'b1, 1'b0); zero_a = 1; zero_b = 1; end
        1: begin set_ops(24'h800000, 24'h800000, 10'h0FF, 10'h0FF, 1'b0, 1'b1); inf_a = 1; inf_b = 1; end
        default: begin set_ops(24'hA00000, 24'h800000, 10'h0FF, 10'h001, 1'b1, 1'b1); sNaN_a = 1; end
      endcase
      pulse_load(1'b1);
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if (outs(g) !== {24'hC00000, 10'h0FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL invalid_case%0d inst%0d: got %h expected %h", k, g, outs(g),
                   {24'hC00000, 10'h0FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        end
      end
      collect(3);
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if (pulses[g] !== 0) begin
          n_fail++;
          $display("FAIL invalid_pulse_width%0d inst%0d: got %0d extra ready cycles expected 0", k, g, pulses[g]);
        end
      end
    end
  endtask

  task automatic test_inf_zero;
    // -3.0 / +0
    set_ops(24'hC00000, 24'h0, 10'h001, 10'h0, 1'b1, 1'b0);
    zero_b = 1;
    pulse_load(1'b1);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (outs(g) !== {24'h800000, 10'h0FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL div_by_zero inst%0d: got %h expected %h", g, outs(g),
                 {24'h800000, 10'h0FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      end
    end
    // +0 / -5.0
    set_ops(24'h0, 24'hA00000, 10'h0, 10'h002, 1'b0, 1'b1);
    zero_a = 1;
    pulse_load(1'b1);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (outs(g) !== {24'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL zero_result inst%0d: got %h expected %h", g, outs(g),
                 {24'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      end
    end
    collect(2);
  endtask

  task automatic test_abort;
    set_ops(24'h800000, 24'hC00000, 10'h0, 10'h0, 1'b0, 1'b0);
    pulse_load(1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_early_ready cycle%0d: got %b expected 0", c, ready_o[0]);
      end
    end
    set_ops(24'hC00000, 24'h800000, 10'h0, 10'h0, 1'b0, 1'b0);
    pulse_load(1'b1);
    collect(30);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (pulses[g] !== 1 || lat[g] !== 25 / itr[g]) begin
        n_fail++;
        $display("FAIL abort_restart inst%0d: got %0d pulses at %0d expected 1 at %0d", g, pulses[g], lat[g], 25 / itr[g]);
      end
      n_checks++;
      if ({c_man[g], c_exp[g], c_rnd[g], c_stk[g]} !== {24'hC00000, 10'h000, 2'b00}) begin
        n_fail++;
        $display("FAIL abort_result inst%0d: got man %h exp %h r%b st%b expected man c00000 exp 000 r0 st0",
                 g, c_man[g], c_exp[g], c_rnd[g], c_stk[g]);
      end
    end
  endtask

  task automatic test_reset_mid_calc;
    set_ops(24'h800000, 24'hC00000, 10'h0, 10'h0, 1'b0, 1'b0);
    pulse_load(1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (outs(g) !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_calc inst%0d: got %h expected 0", g, outs(g));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    collect(30);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (pulses[g] !== 0 || outs(g) !== '0) begin
        n_fail++;
        $display("FAIL after_reset_quiet inst%0d: got %0d pulses outs %h expected 0 pulses outs 0", g, pulses[g], outs(g));
      end
    end
    // Fill the outputs with a real result, then clear via load with op_div=0.
    set_ops(24'h800000, 24'hC00000, 10'h0, 10'h0, 1'b1, 1'b0);
    pulse_load(1'b1);
    collect(30);
    set_ops(24'hC00000, 24'h800000, 10'h005, 10'h001, 1'b1, 1'b0);
    pulse_load(1'b0);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (outs(g) !== '0) begin
        n_fail++;
        $display("FAIL clear_load inst%0d: got %h expected 0", g, outs(g));
      end
    end
    collect(30);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (pulses[g] !== 0 || outs(g) !== '0) begin
        n_fail++;
        $display("FAIL clear_stays inst%0d: got %0d pulses outs %h expected 0 pulses outs 0", g, pulses[g], outs(g));
      end
    end
  endtask

  task automatic test_random_sweep;
    logic [23:0] ma, mb;
    logic [9:0]  ea, eb, e_exp;
    logic        sa, sb, lt;
    logic [63:0] num, qv, rv;
    for (int n = 0; n < 150; n++) begin
      ma = {1'b1, 23'($urandom)};
      mb = (n % 10 == 3) ? ma : {1'b1, 23'($urandom)};
      if (n % 10 == 7) mb = 24'h800000;
      ea = 10'($urandom);
      eb = 10'($urandom);
      sa = 1'($urandom);
      sb = 1'($urandom);
      // Quotient to 25 significant bits: value in [1,2) scaled by 2^24.
      lt    = (ma < mb);
      num   = (lt ? (64'(ma) << 1) : 64'(ma)) << 24;
      qv    = num / 64'(mb);
      rv    = num % 64'(mb);
      e_exp = ea - eb - (lt ? 10'd1 : 10'd0);
      set_ops(ma, mb, ea, eb, sa, sb);
      pulse_load(1'b1);
      collect(26);
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if (lat[g] !== 25 / itr[g] || pulses[g] !== 1) begin
          n_fail++;
          $display("FAIL rand_latency n%0d inst%0d: got lat %0d pulses %0d expected lat %0d pulses 1",
                   n, g, lat[g], pulses[g], 25 / itr[g]);
        end
        n_checks++;
        if ({c_man[g], c_rnd[g], c_stk[g], c_exp[g], c_sgn[g], c_fr[g], c_iv[g], c_dz[g]} !==
            {qv[24:1], qv[0], (rv != 0), e_exp, sa ^ sb, 3'b000}) begin
          n_fail++;
          $display("FAIL rand_result n%0d inst%0d a=%h b=%h: got man %h r%b st%b exp %h s%b fr%b iv%b dz%b expected man %h r%b st%b exp %h s%b",
                   n, g, ma, mb, c_man[g], c_rnd[g], c_stk[g], c_exp[g], c_sgn[g], c_fr[g], c_iv[g], c_dz[g],
                   qv[24:1], qv[0], (rv != 0), e_exp, sa ^ sb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_divides();
    test_invalid();
    test_inf_zero();
    test_abort();
    test_reset_mid_calc();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
